// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Owns the PC, drives a combinational instruction memory and registers each
// fetched word into a one-entry fetch slot with a valid/ready handshake toward
// decode. Unconditional jumps are resolved at fetch (zero bubble), execute may
// redirect the PC, and a jump to its own address parks the sequencer in HALT.
// Optional build macro: IFETCH_PERF_CNT_EN adds saturating perf counters.
module ifetch_ctrl #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [5:0]        JUMP_OP  = 6'b010100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q,    if_pc_d;
    logic              halted_q,   halted_d;

    logic              load_s;
    logic              is_jump_s;
    logic [ADDR_W-1:0] jump_tgt_s;
    logic [ADDR_W-1:0] pc_inc_s;

    // Next-state logic: redirect beats loading; a load fills the slot and steps or jumps the PC.
    always_comb begin
        is_jump_s  = (imem_instr[31:26] == JUMP_OP);
        jump_tgt_s = imem_instr[ADDR_W-1:0];
        pc_inc_s   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        load_s     = (state_q == ST_RUN) && !redirect_valid && (!if_valid_q || id_ready);

        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        case (state_q)
            ST_IDLE: begin
                // Redirects are ignored here; the first fetch happens after entering RUN.
                if (run_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (load_s) begin
                    if_instr_d = imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (is_jump_s) begin
                        pc_d = jump_tgt_s;
                        // A jump to itself is the program-end idiom.
                        if (jump_tgt_s == pc_q) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        pc_d = pc_inc_s;
                    end
                end else begin
                    // Stall: decode holds the slot, everything keeps its value.
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end else if (id_ready) begin
                    // The self-jump drains out of the slot; nothing else is fetched.
                    if_valid_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a quiet IDLE.
                state_d    = ST_IDLE;
                if_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // State and fetch-slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0000_0000;
            if_pc_q    <= {ADDR_W{1'b0}};
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = halted_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q,   perf_stall_d;

    // Saturating counters for slot loads and decode back-pressure cycles.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (load_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if (if_valid_q && !id_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Perf counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_stall_q   <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios plus a randomized run.
// Expected deliveries come from a program-order interpreter of the memory
// image and are checked by a negedge monitor on every decode handshake.
module tb_ifetch_ctrl;

    localparam logic [5:0] JUMP_OP = 6'b010100;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic [15:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [0:65535];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    bit          prev_stall = 1'b0;
    logic [15:0] prev_pc;
    logic [31:0] prev_instr;

    assign imem_instr = mem[imem_addr];

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_en         (run_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit jmp);
        logic [31:0] w;
        w = $urandom;
        if (jmp) begin
            w[31:26] = JUMP_OP;
        end else if (w[31:26] == JUMP_OP) begin
            w[31:26] = ~JUMP_OP;
        end
        return w;
    endfunction

    function automatic logic [31:0] jump_word(input logic [15:0] tgt);
        logic [31:0] w;
        w = rand_word(1'b1);
        w[15:0] = tgt;
        return w;
    endfunction

    // Interpreter: program-order walk from start, ending at a self-jump.
    task automatic push_from(input logic [15:0] start);
        logic [15:0] p;
        logic [31:0] w;
        exp_t        e;
        p = start;
        exp_q.delete();
        for (int n = 0; n < 4096; n++) begin
            w = mem[p];
            e.pc = p;
            e.instr = w;
            exp_q.push_back(e);
            if (w[31:26] == JUMP_OP) begin
                if (w[15:0] == p) break;
                p = w[15:0];
            end else begin
                p = p + 16'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_en = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start();
        push_from(16'h0000);
        run_en = 1'b1;
        step();
        run_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_pc"}, {16'd0, if_pc}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_imem_addr"}, {16'd0, imem_addr}, 32'd0);
    endtask

    task automatic wait_pc(input logic [15:0] t);
        for (int i = 0; i < 40; i++) begin
            if (if_valid && (if_pc == t)) break;
            step();
        end
        chk("wait_pc", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, t});
    endtask

    // Monitor: pop and compare on each handshake; verify the slot holds steady under back-pressure.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {if_valid, 15'd0, if_pc}, {1'b1, 15'd0, prev_pc});
                chk("stall_hold_instr", if_instr, prev_instr);
            end
            if (if_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_delivery actual_pc=%h instr=%h expected=none", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", {16'd0, if_pc}, {16'd0, e.pc});
                    chk("deliver_instr", if_instr, e.instr);
                end
            end
            prev_stall = if_valid && !id_ready && !redirect_valid;
            prev_pc = if_pc;
            prev_instr = if_instr;
        end
    end

    initial begin
        logic [15:0] seq_a [10];
`ifdef IFETCH_PERF_CNT_EN
        logic [31:0] p0;
`endif
        seq_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                  16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};

        for (int a = 0; a < 65536; a++) begin
            mem[a] = rand_word($urandom_range(0, 15) == 0);
        end
        for (int a = 0; a < 4; a++) mem[a] = rand_word(1'b0);
        mem[4] = jump_word(16'h0010);
        for (int a = 16; a < 20; a++) mem[a] = rand_word(1'b0);
        mem[20] = jump_word(16'h0014);
        mem[16'hFFFF] = rand_word(1'b0);

        // Reset, start, straight-line fetch, zero-bubble jump, then halt.
        do_reset();
        chk_reset_state("reset");
        id_ready = 1'b1;
        start();
        chk("idle_to_run_no_fetch", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stream_pc", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, seq_a[i]});
        end
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_addr", {16'd0, imem_addr}, 32'h0000_0014);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_hold_addr", {16'd0, imem_addr}, 32'h0000_0014);
            chk("halt_slot_drained", {31'd0, if_valid}, 32'd0);
            chk("halt_hold_flag", {31'd0, halted}, 32'd1);
        end

        // Leave HALT through a redirect to 0.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        push_from(16'h0000);
        step();
        redirect_valid = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_flush", {31'd0, if_valid}, 32'd0);
        step();
        chk("resume_pc0", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0000});
        step();
        chk("resume_pc1", {16'd0, if_pc}, 32'h0000_0001);

        // PC wrap from 0xFFFF to 0x0000.
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        push_from(16'hFFFF);
        step();
        redirect_valid = 1'b0;
        chk("wrap_flush", {31'd0, if_valid}, 32'd0);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000_FFFF);
        step();
        chk("wrap_pc_ffff", {16'd0, if_pc}, 32'h0000_FFFF);
        step();
        chk("wrap_pc_0", {16'd0, if_pc}, 32'h0000_0000);
        chk("wrap_addr_1", {16'd0, imem_addr}, 32'h0000_0001);

        // Halt again, then reset while halted.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0014;
        push_from(16'h0014);
        step();
        redirect_valid = 1'b0;
        step();
        chk("rehalt_pc", {16'd0, if_pc}, 32'h0000_0014);
        chk("rehalt_flag", {31'd0, halted}, 32'd1);
        step();
        step();
        do_reset();
        chk_reset_state("reset_in_halt");

        // Redirect while IDLE has no effect.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0055;
        step();
        step();
        redirect_valid = 1'b0;
        chk("idle_redirect_addr", {16'd0, imem_addr}, 32'h0000_0000);
        chk("idle_redirect_valid", {31'd0, if_valid}, 32'd0);

        // Redirect with the slot holding pc=5 under back-pressure.
        for (int a = 4; a < 10; a++) mem[a] = rand_word(1'b0);
        do_reset();
        id_ready = 1'b1;
        start();
        wait_pc(16'h0005);
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0008;
        push_from(16'h0008);
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        chk("redirect_flush", {31'd0, if_valid}, 32'd0);
        step();
        chk("redirect_target", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0008});

        // Three-cycle decode stall with pc=2 in the slot.
        do_reset();
        id_ready = 1'b1;
        start();
        wait_pc(16'h0002);
        id_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
        p0 = perf_stall;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_slot_pc", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0002});
            chk("stall_slot_instr", if_instr, mem[2]);
            chk("stall_pc", {16'd0, imem_addr}, 32'h0000_0003);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_stall_delta", perf_stall - p0, 32'd3);
        p0 = perf_fetched;
`endif
        id_ready = 1'b1;
        step();
        chk("stall_release_pc", {16'd0, if_pc}, 32'h0000_0003);
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetched_delta", perf_fetched - p0, 32'd1);
`endif

        // Randomized run: random back-pressure and occasional redirects.
        do_reset();
        id_ready = 1'b1;
        start();
        for (int c = 0; c < 3000; c++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 16'($urandom);
                push_from(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
